// File: rtl/core_pkg.sv
// Shared types and instruction-field layout for the multi-cycle core.
// Imported by the ALU and by the mc_core top.
package core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LI  = 3'b100,
    OP_LD  = 3'b101,
    OP_ST  = 3'b110,
    OP_SYS = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 6;
  localparam int RA_MSB   = 5;
  localparam int RA_LSB   = 4;
  localparam int RB_MSB   = 3;
  localparam int RB_LSB   = 2;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;
  localparam int OFF_MSB  = 4;
  localparam int HALT_BIT = 5;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: ADD/SUB/AND/XOR with carry and zero.
// SUB carry reports "no borrow", i.e. a >= b.
module core_alu
  import core_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] sum_s;
  logic [DW:0] diff_s;

  // Result and carry selection per opcode
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    result = {DW{1'b0}};
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_s[DW-1:0];
        carry  = sum_s[DW];
      end
      OP_SUB: begin
        result = diff_s[DW-1:0];
        carry  = ~diff_s[DW];
      end
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
      default: begin
        result = {DW{1'b0}};
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == {DW{1'b0}});

endmodule

// File: rtl/mc_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM state machine with synchronous
// instruction ROM and a req/ack data memory port.
module mc_core
  import core_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PCW = 12,
  parameter int IW  = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack,
  output logic           zero_flag,
  output logic           carry_flag,
  output logic           done
);

  state_e               state_r;
  logic [PCW-1:0]       pc_r;
  logic [IW-1:0]        ir_r;
  logic [3:0][DW-1:0]   regs_r;
  logic [DW-1:0]        a_r;
  logic [DW-1:0]        b_r;
  logic                 zero_r;
  logic                 carry_r;
  logic                 done_r;
  logic                 req_r;
  logic                 we_r;
  logic [DW-1:0]        daddr_r;
  logic [DW-1:0]        dwdata_r;

  op_e                  op_s;
  logic [1:0]           ra_s;
  logic [DW-1:0]        imm_s;
  logic [PCW-1:0]       off_s;
  logic [PCW-1:0]       pc_inc_s;
  logic [PCW-1:0]       pc_br_s;
  logic [DW-1:0]        alu_res_s;
  logic                 alu_carry_s;
  logic                 alu_zero_s;

  assign op_s     = op_e'(ir_r[OP_MSB:OP_LSB]);
  assign ra_s     = ir_r[RA_MSB:RA_LSB];
  assign imm_s    = {{(DW-4){1'b0}}, ir_r[IMM_MSB:IMM_LSB]};
  assign off_s    = {{(PCW-OFF_MSB-1){ir_r[OFF_MSB]}}, ir_r[OFF_MSB:0]};
  // Both adds wrap naturally at PCW bits
  assign pc_inc_s = pc_r + {{(PCW-1){1'b0}}, 1'b1};
  assign pc_br_s  = pc_r + off_s;

  core_alu #(.DW(DW)) u_alu (
    .op     (op_s),
    .a      (a_r),
    .b      (b_r),
    .result (alu_res_s),
    .carry  (alu_carry_s),
    .zero   (alu_zero_s)
  );

  // Control FSM, PC, register file, flags and memory-port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= {PCW{1'b0}};
      ir_r     <= {IW{1'b0}};
      regs_r   <= {(4*DW){1'b0}};
      a_r      <= {DW{1'b0}};
      b_r      <= {DW{1'b0}};
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      done_r   <= 1'b0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      daddr_r  <= {DW{1'b0}};
      dwdata_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            pc_r    <= {PCW{1'b0}};
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: state_r <= ST_DECODE;
        ST_DECODE: begin
          ir_r    <= imem_data;
          a_r     <= regs_r[imem_data[RA_MSB:RA_LSB]];
          b_r     <= regs_r[imem_data[RB_MSB:RB_LSB]];
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
              regs_r[ra_s] <= alu_res_s;
              zero_r       <= alu_zero_s;
              if ((op_s == OP_ADD) || (op_s == OP_SUB)) begin
                carry_r <= alu_carry_s;
              end else begin
                carry_r <= carry_r;
              end
              pc_r    <= pc_inc_s;
              state_r <= ST_FETCH;
            end
            OP_LI: begin
              regs_r[ra_s] <= imm_s;
              pc_r         <= pc_inc_s;
              state_r      <= ST_FETCH;
            end
            OP_LD, OP_ST: begin
              req_r    <= 1'b1;
              we_r     <= (op_s == OP_ST);
              daddr_r  <= b_r;
              dwdata_r <= a_r;
              state_r  <= ST_MEM;
            end
            OP_SYS: begin
              if (ir_r[HALT_BIT]) begin
                done_r  <= 1'b1;
                state_r <= ST_HALT;
              end else begin
                pc_r    <= zero_r ? pc_br_s : pc_inc_s;
                state_r <= ST_FETCH;
              end
            end
            default: state_r <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (!we_r) begin
              regs_r[ra_s] <= dmem_rdata;
              zero_r       <= (dmem_rdata == {DW{1'b0}});
            end else begin
              zero_r       <= zero_r;
            end
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            pc_r    <= pc_inc_s;
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_HALT: begin
          done_r  <= 1'b1;
          state_r <= ST_HALT;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign imem_addr  = pc_r;
  assign dmem_req   = req_r;
  assign dmem_we    = we_r;
  assign dmem_addr  = daddr_r;
  assign dmem_wdata = dwdata_r;
  assign zero_flag  = zero_r;
  assign carry_flag = carry_r;
  assign done       = done_r;

endmodule
